dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu_pkg.sv | 25 ++
 rtl/dmem_lsu_ram.sv | 45 ++++
 rtl/dmem_lsu.sv | 163 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access-size
// encodings and the byte-lane mask helper used to build write enables.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  // Byte enables for an access of the given size starting at lane 'offset'.
  // Returned for the widest (64-bit) word; narrower memories truncate.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/dmem_lsu_ram.sv
// Byte-enable synchronous single-port RAM with a registered read port.
// The read register only updates on a read access, so the output holds
// while the response it feeds is stalled. The array itself has no reset.
module dmem_lsu_ram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte-lane writes: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Next read value: capture the addressed word on a read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[idx];
  end

  // Registered read data (data path, not reset).
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: valid/ready request/response wrapper around
// a byte-enable RAM, with alignment/range checking and load extension.
// One response per accepted request, one cycle later, in order.
// Optional macro DMEM_LSU_ERRCNT_EN adds a saturating 16-bit error counter;
// without it err_cnt is tied to zero.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       err_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int HI_SH = OFF_W + IDX_W;

  // Zero- or sign-extend the right-aligned lane data to the full word.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0] size,
                                               input logic uns);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_B:    r = uns ? DATA_W'(v[7:0])  : DATA_W'($signed(v[7:0]));
      SZ_H:    r = uns ? DATA_W'(v[15:0]) : DATA_W'($signed(v[15:0]));
      SZ_W:    r = uns ? DATA_W'(v[31:0]) : DATA_W'($signed(v[31:0]));
      default: r = v;
    endcase
    return r;
  endfunction

  logic              accept;
  logic [2:0]        req_off;
  logic              req_oor;
  logic              req_misal;
  logic              req_err;
  logic [NB-1:0]     req_be;
  logic [DATA_W-1:0] req_wdata_sh;
  logic [DATA_W-1:0] ram_rdata;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              rsp_we_q,    rsp_we_d;
  logic              rsp_uns_q,   rsp_uns_d;
  logic [1:0]        rsp_size_q,  rsp_size_d;
  logic [2:0]        rsp_off_q,   rsp_off_d;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Request decode: lane offset, range/alignment errors, store lanes and data.
  always_comb begin
    req_off = 3'(req_addr[OFF_W-1:0]);
    req_oor = |(req_addr >> HI_SH);
    case (req_size)
      SZ_H:    req_misal = req_off[0];
      SZ_W:    req_misal = (req_off[1:0] != 2'b00);
      SZ_D:    req_misal = (DATA_W == 32) || (req_off != 3'b000);
      default: req_misal = 1'b0;
    endcase
    req_err      = req_oor || req_misal;
    req_be       = NB'(lane_mask(req_size, req_off));
    req_wdata_sh = req_wdata << {req_off, 3'b000};
  end

  // Erroring stores turn into reads so the array is left untouched.
  dmem_lsu_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (req_we && !req_err),
    .idx   (req_addr[OFF_W +: IDX_W]),
    .be    (req_be),
    .wdata (req_wdata_sh),
    .rdata (ram_rdata)
  );

  // Response slot: load on accept, clear on consume, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_we_d    = rsp_we_q;
    rsp_uns_d   = rsp_uns_q;
    rsp_size_d  = rsp_size_q;
    rsp_off_d   = rsp_off_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_we_d    = req_we;
      rsp_uns_d   = req_unsigned;
      rsp_size_d  = req_size;
      rsp_off_d   = req_off;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response control registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_uns_q   <= 1'b0;
      rsp_size_q  <= 2'b00;
      rsp_off_q   <= 3'b000;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      rsp_uns_q   <= rsp_uns_d;
      rsp_size_q  <= rsp_size_d;
      rsp_off_q   <= rsp_off_d;
    end
  end

  // Outputs are gated by rsp_valid so they read zero in and right after reset.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !rsp_we_q)
                   ? extend(ram_rdata >> {rsp_off_q, 3'b000}, rsp_size_q, rsp_uns_q)
                   : '0;

`ifdef DMEM_LSU_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted erroring requests.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && req_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 16'h0000;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu (DATA_W=32, DEPTH_WORDS=256).
module tb_dmem_lsu;

  localparam int DATA_W      = 32;
  localparam int DEPTH_WORDS = 256;
  localparam int ADDR_W      = 32;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;
`ifdef DMEM_LSU_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [15:0]       err_cnt;

  dmem_lsu #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .err_cnt      (err_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        mon_e;
  logic [7:0]  mdl [MEM_BYTES];
  int          n_chk;
  int          n_fail;
  int          exp_errs;
  bit          bp;
  logic [31:0] stall_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed memory, push expected response.
  task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    rsp_t        r;
    logic        err;
    logic [31:0] v;
    int          nb;
    nb  = 1 << sz;
    err = (addr >= MEM_BYTES) || (sz == 2'd3) ||
          (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    r.err   = err;
    r.rdata = 32'h0;
    if (err) begin
      if (exp_errs < 65535) exp_errs++;
    end else if (we) begin
      for (int i = 0; i < nb; i++) mdl[addr + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[addr + i];
      if (!uns && nb < 4 && v[8*nb-1]) begin
        for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      end
      r.rdata = v;
    end
    sb.push_back(r);
  endtask

  // Present one request until accepted; called and returns at posedge+1.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    int t;
    bit done;
    bit acc;
    t = 0; done = 0; acc = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    while (!done) begin
      if (bp) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_ready) begin
        model_req(we, sz, uns, addr, wd);
        done = 1; acc = 1;
      end else if (++t > 50) begin
        chk("accept_timeout", req_ready, 1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc) chk("latency_rsp_valid", rsp_valid, 1);
  endtask

  task automatic drain();
    int t;
    bp = 0;
    rsp_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Response monitor: compare each consumed response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; exp_errs = 0; bp = 0;
    for (int i = 0; i < MEM_BYTES; i++) mdl[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_req_ready", req_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then byte/half loads
    issue(1, 2'd2, 0, 32'h0, 32'h04030201);
    issue(0, 2'd0, 1, 32'h2, 32'h0);
    issue(0, 2'd1, 1, 32'h2, 32'h0);
    drain();

    // Byte store, sign-extended load, merged word
    issue(1, 2'd0, 0, 32'h3, 32'h00000084);
    issue(0, 2'd0, 0, 32'h3, 32'h0);
    issue(0, 2'd2, 0, 32'h0, 32'h0);
    drain();

    // Misaligned accesses leave memory alone
    issue(0, 2'd2, 0, 32'h2, 32'h0);
    issue(1, 2'd1, 0, 32'h1, 32'hFFFFFFFF);
    issue(0, 2'd2, 0, 32'h0, 32'h0);
    drain();
    chk("err_cnt_after_misaligned", err_cnt, ERRCNT_ON ? 64'd2 : 64'd0);

    // Out-of-range store
    issue(1, 2'd2, 0, 32'h400, 32'hDEADBEEF);
    issue(0, 2'd2, 0, 32'h0, 32'h0);
    drain();

    // Half/byte extension, illegal size, top of memory
    issue(1, 2'd1, 0, 32'h6, 32'h1234BEEF);
    issue(0, 2'd1, 0, 32'h6, 32'h0);
    issue(0, 2'd1, 1, 32'h6, 32'h0);
    issue(0, 2'd0, 0, 32'h7, 32'h0);
    issue(0, 2'd0, 1, 32'h7, 32'h0);
    issue(0, 2'd2, 1, 32'h4, 32'h0);
    issue(0, 2'd3, 0, 32'h8, 32'h0);
    issue(1, 2'd0, 0, 32'h3FF, 32'h0000005A);
    issue(0, 2'd0, 1, 32'h3FF, 32'h0);
    issue(0, 2'd2, 0, 32'h3FC, 32'h0);
    issue(0, 2'd1, 0, 32'h3FE, 32'h0);
    issue(1, 2'd0, 0, 32'h80000000, 32'h11);
    drain();

    // Random traffic under random response back-pressure
    bp = 1;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? (32'h400 + 32'($urandom_range(0, 63)))
                                       : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();

    // Stalled response holds and blocks the next request
    rsp_ready = 1'b0;
    issue(0, 2'd2, 0, 32'h0, 32'h0);
    stall_exp = sb[0].rdata;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
    req_addr = 32'h1; req_wdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_rdata", rsp_rdata, stall_exp);
      chk("stall_rsp_err", rsp_err, 0);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("resume_req_ready", req_ready, 1);
    model_req(0, 2'd0, 1, 32'h1, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("resume_rsp_valid", rsp_valid, 1);
    drain();

    // Asynchronous reset with a store response pending
    rsp_ready = 1'b0;
    issue(1, 2'd2, 0, 32'h10, 32'hCAFEF00D);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_rsp_rdata", rsp_rdata, 0);
    chk("async_rst_rsp_err", rsp_err, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_req_ready", req_ready, 1);
    sb.delete();
    exp_errs = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    issue(0, 2'd2, 0, 32'h2, 32'h0);
    drain();
    chk("err_cnt_final", err_cnt, ERRCNT_ON ? 64'(exp_errs) : 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
